// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock.
// A start/done handshake converts one unsigned word into DIGITS packed BCD nibbles for the excess-3 stage.
module bin_to_bcd_seq #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [BIN_W-1:0]   bin_sr;
   logic [BCD_W-1:0]   work;
   logic [BCD_W-1:0]   work_adj;
   logic [BCD_W-1:0]   work_shift;
   logic [CNT_W-1:0]   bit_cnt;
   logic               last_bit;

   // Every digit >= 5 gets +3 before the shift so that doubling carries correctly into the next digit.
   always_comb begin
      work_adj = work;
      for (int k = 0; k < DIGITS; k++) begin
         if (work[4*k +: 4] >= 4'd5) begin
            work_adj[4*k +: 4] = work[4*k +: 4] + 4'd3;
         end
      end
   end

   assign work_shift = {work_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
   assign last_bit   = (bit_cnt == CNT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (last_bit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // The result register is only written on the final shift, so it holds through IDLE and the next conversion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_sr  <= '0;
         work    <= '0;
         bit_cnt <= '0;
         bcd_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  bin_sr  <= bin_in;
                  work    <= '0;
                  bit_cnt <= CNT_W'(BIN_W);
               end
            end
            SHIFT: begin
               bin_sr  <= {bin_sr[BIN_W-2:0], 1'b0};
               work    <= work_shift;
               bit_cnt <= bit_cnt - 1'b1;
               if (last_bit) begin
                  bcd_out <= work_shift;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
